// File: rtl/bcd_to_binary_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// State encoding, reverse double-dabble constants and the team seven-segment
// digit codes (bit 6 = g ... bit 0 = a) used by the display encoder.
package bcd_to_binary_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ        = 4'd3;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_MAX        = 4'd9;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

endpackage

// File: rtl/bcd_sub_adjust.sv
// Per-digit correction for reverse double-dabble: a digit that reads 8 or
// more after the right shift had a tens carry shifted into it; subtract 3.
module bcd_sub_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // 4-bit subtract, no borrow out of the digit
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_ADJ_THRESH) o_digit = i_digit - BCD_ADJ;
  end

endmodule

// File: rtl/seg_to_bcd.sv
// Seven-segment pattern to BCD digit decoder (only built when
// BCD_TO_BINARY_SEG_IN_EN is defined). Any pattern that is not one of the
// ten digit codes, including all-off, raises o_invalid.
`ifdef BCD_TO_BINARY_SEG_IN_EN
module seg_to_bcd
  import bcd_to_binary_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_invalid
);

  // match against the shared digit table
  always_comb begin
    o_bcd     = '0;
    o_invalid = 1'b1;
    for (int unsigned d = 0; d < 10; d++) begin
      if (i_seg == SEG_DIGIT[d]) begin
        o_bcd     = 4'(d);
        o_invalid = 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/bcd_to_binary.sv
// Iterative BCD-to-binary converter (reverse double-dabble), start/done
// handshake, one conversion at a time, result held until the next start.
// Optional macro BCD_TO_BINARY_SEG_IN_EN: replaces bcd_in with seven-segment
// input seg_in, decoded combinationally before the load.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int unsigned NDIGITS = 2,
  parameter int unsigned BIN_W   = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
`ifdef BCD_TO_BINARY_SEG_IN_EN
  input  logic [7*NDIGITS-1:0]   seg_in,
`else
  input  logic [4*NDIGITS-1:0]   bcd_in,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [BIN_W-1:0]       bin_out
);

  localparam int unsigned W_BCD  = 4 * NDIGITS;
  localparam int unsigned W_WORK = W_BCD + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  state_t              r_state, w_state_nxt;
  logic [W_WORK-1:0]   r_work, w_work_nxt, w_shifted, w_adjusted;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_inval, w_inval_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic [BIN_W-1:0]    r_bin, w_bin_nxt;
  logic [W_BCD-1:0]    w_bcd;
  logic [NDIGITS-1:0]  w_digit_bad;
  logic                w_bad;

`ifdef BCD_TO_BINARY_SEG_IN_EN
  for (genvar g = 0; g < NDIGITS; g++) begin : g_seg
    seg_to_bcd u_seg (
      .i_seg     (seg_in[7*g +: 7]),
      .o_bcd     (w_bcd[4*g +: 4]),
      .o_invalid (w_digit_bad[g])
    );
  end
`else
  assign w_bcd = bcd_in;
  for (genvar g = 0; g < NDIGITS; g++) begin : g_chk
    assign w_digit_bad[g] = (bcd_in[4*g +: 4] > BCD_MAX);
  end
`endif

  assign w_bad     = |w_digit_bad;
  assign w_shifted = r_work >> 1;

  // binary field passes straight through; each BCD field gets corrected
  assign w_adjusted[BIN_W-1:0] = w_shifted[BIN_W-1:0];
  for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
    bcd_sub_adjust u_adj (
      .i_digit (w_shifted[BIN_W + 4*g +: 4]),
      .o_digit (w_adjusted[BIN_W + 4*g +: 4])
    );
  end

  // next-state and datapath updates
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_inval_nxt = r_inval;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_bin_nxt   = r_bin;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_bad) begin
            w_inval_nxt = 1'b1;
            w_state_nxt = FINISH;
          end else begin
            w_inval_nxt = 1'b0;
            w_work_nxt  = {w_bcd, {BIN_W{1'b0}}};
            w_cnt_nxt   = '0;
            w_state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        w_work_nxt = w_adjusted;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = FINISH;
      end
      FINISH: begin
        w_done_nxt = 1'b1;
        if (r_inval) begin
          w_bin_nxt = '0;
          w_err_nxt = 1'b1;
        end else begin
          w_bin_nxt = r_work[BIN_W-1:0];
          w_err_nxt = 1'b0;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_inval <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_bin   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_inval <= w_inval_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_bin   <= w_bin_nxt;
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign err     = r_err;
  assign bin_out = r_bin;

endmodule
